fifo_wr_arbiter: RTL

- Round-robin write-port arbiter that shares one synchronous FIFO write port among R requesters.
- Grants one requester at a time for a burst of up to BURST words.
- Obeys the FIFO full flag and returns a per-word ack to the granted requester.
- Sits between producer blocks and the buffer/FIFO datapath; replaces ad-hoc enable/clock muxing with a single-clock handshake.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter family.
//   arb_state_t : arbiter FSM state (idle / burst owned)
//   onehot()    : index -> one-hot vector (up to MaxReq requesters)
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Widest requester vector the onehot helper can produce.
  localparam int unsigned MaxReq = 32;

  // Returns a MaxReq-wide one-hot vector; callers slice off the low r bits.
  // An index outside [0, r) yields all zeros.
  function automatic logic [MaxReq-1:0] onehot(input int unsigned idx, input int unsigned r);
    logic [MaxReq-1:0] v;
    v = '0;
    if (idx < r && idx < MaxReq) begin
      v = MaxReq'(1) << idx;
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   idx_o   : first set request scanning ptr_i, ptr_i+1, ... wrapping mod R
//   valid_o : high when any request is set (idx_o is 0 otherwise)
module rr_pick #(
  parameter int unsigned R = 4,
  localparam int unsigned PW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < R; k++) begin
      logic [PW-1:0] cand;
      cand = PW'((32'(ptr_i) + k) % R);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among R producers.
// A grant owns the port for up to BURST words; a one-cycle idle bubble separates bursts.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_i, data_i : per-requester write request / data
//   ack_o         : one-hot, word from the granted requester accepted this cycle
//   gnt_o         : registered one-hot grant, zero when idle
//   fifo_full_i   : FIFO full flag (stalls the burst)
//   fifo_wr_o     : FIFO write strobe, fifo_data_o : FIFO write data
//   busy_o        : burst owned, burst_cnt_o : words written in the current burst
module fifo_wr_arbiter #(
  parameter int unsigned n     = 32,
  parameter int unsigned R     = 4,
  parameter int unsigned BURST = 16,
  localparam int unsigned CW   = $clog2(BURST + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [R-1:0]  req_i,
  input  logic [n-1:0]  data_i [0:R-1],
  output logic [R-1:0]  ack_o,
  output logic [R-1:0]  gnt_o,
  input  logic          fifo_full_i,
  output logic          fifo_wr_o,
  output logic [n-1:0]  fifo_data_o,
  output logic          busy_o,
  output logic [CW-1:0] burst_cnt_o
);

  import fifo_arb_pkg::*;

  localparam int unsigned PW = (R > 1) ? $clog2(R) : 1;

  arb_state_t    state_q, state_d;
  logic [R-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [PW-1:0]     pick_idx;
  logic              pick_valid;
  logic [MaxReq-1:0] pick_oh;
  logic              wr;

  rr_pick #(
    .R(R)
  ) u_pick (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  assign pick_oh = onehot(32'(pick_idx), R);

  // Reset gates the strobe so no word is accepted in the reset cycle.
  assign wr = (state_q == ARB_BURST) & req_i[gidx_q] & ~fifo_full_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_BURST;
          gidx_d  = pick_idx;
          gnt_d   = pick_oh[R-1:0];
          cnt_d   = '0;
        end
      end
      ARB_BURST: begin
        if (wr) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Release takes effect even while stalled on full; pointer advances regardless.
        if ((wr && cnt_q == CW'(BURST - 1)) || !req_i[gidx_q]) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (gidx_q == PW'(R - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt_o       = gnt_q;
    busy_o      = (state_q == ARB_BURST);
    burst_cnt_o = cnt_q;
    fifo_wr_o   = wr;
    fifo_data_o = wr ? data_i[gidx_q] : '0;
    ack_o       = wr ? gnt_q : '0;
  end

endmodule
